// File: rtl/popcount_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ requesters into one shared popcount
// datapath, with a single registered response slot that streams at one word per cycle.
module popcount_arbiter #(
    parameter int unsigned INPUTBITWIDTH  = 16,
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned OUTPUTBITWIDTH = $clog2(INPUTBITWIDTH),
    parameter int unsigned IDWIDTH        = $clog2(NUM_REQ)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*INPUTBITWIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [IDWIDTH-1:0]                 rsp_id,
    output logic [OUTPUTBITWIDTH-1:0]          rsp_count,
    output logic                               rsp_carry
);

    localparam int unsigned CW = OUTPUTBITWIDTH + 1;

    logic                       rsp_valid_q, rsp_valid_d;
    logic [IDWIDTH-1:0]         rsp_id_q, rsp_id_d;
    logic [CW-1:0]              rsp_sum_q, rsp_sum_d;
    logic [IDWIDTH-1:0]         last_grant_q, last_grant_d;

    logic                       slot_free_c;
    logic                       sel_found_c;
    logic [IDWIDTH-1:0]         sel_c;
    logic [INPUTBITWIDTH-1:0]   word_c;
    logic [CW-1:0]              pop_c;
    logic                       accept_c;

    assign slot_free_c = !rsp_valid_q || rsp_ready;

    // Round-robin search starting one past the last accepted requester.
    always_comb begin
        logic [IDWIDTH-1:0] cand;
        sel_found_c = 1'b0;
        sel_c       = '0;
        cand        = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = IDWIDTH'((32'(last_grant_q) + off) % NUM_REQ);
            if (!sel_found_c && req_valid[cand]) begin
                sel_found_c = 1'b1;
                sel_c       = cand;
            end
        end
    end

    // Grant is withheld during reset and whenever the response slot is occupied.
    always_comb begin
        req_ready = '0;
        if (sel_found_c && slot_free_c && !rst) begin
            req_ready[sel_c] = 1'b1;
        end
    end

    assign accept_c = |(req_valid & req_ready);

    // Shared datapath: one word mux followed by one popcount.
    always_comb begin
        word_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (sel_c == IDWIDTH'(i)) begin
                word_c = req_data[i*INPUTBITWIDTH +: INPUTBITWIDTH];
            end
        end
    end

    always_comb begin
        pop_c = '0;
        for (int unsigned b = 0; b < INPUTBITWIDTH; b++) begin
            pop_c = pop_c + CW'(word_c[b]);
        end
    end

    // Next state of the response slot and the round-robin pointer.
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_sum_d    = rsp_sum_q;
        last_grant_d = last_grant_q;
        if (accept_c) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = sel_c;
            rsp_sum_d    = pop_c;
            last_grant_d = sel_c;
        end else if (rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_sum_q    <= '0;
            last_grant_q <= IDWIDTH'(NUM_REQ - 1);
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_sum_q    <= rsp_sum_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_count = rsp_sum_q[OUTPUTBITWIDTH-1:0];
    assign rsp_carry = rsp_sum_q[OUTPUTBITWIDTH];

endmodule
